mem_bank_scan: RTL



---
 rtl/mem_scan_pkg.sv | 15 +
 rtl/mem_scan_tag_pipe.sv | 100 ++++++++++
 rtl/mem_bank_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types and helpers for the multi-bank memory read scanner.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_scan_tag_pipe.sv
// Tag pipeline that realigns memory read data with its bank/address tag.
// MEM_SCAN_WRITE_FWD_EN: in-flight entries capture matching snooped writes.
module mem_scan_tag_pipe
    import mem_scan_pkg::*;
#(
    parameter type         type_t       = logic,
    parameter int unsigned OUTPUT_DELAY = 0,
    parameter int unsigned BANK_WIDTH   = 1,
    parameter int unsigned ADDR_W       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  iss_valid,
    input  logic                  iss_last,
    input  logic [BANK_WIDTH-1:0] iss_bank,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  wea,
    input  logic [BANK_WIDTH-1:0] banka,
    input  logic [ADDR_W-1:0]     addra,
    input  type_t                 dia,
    input  type_t                 dob,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [BANK_WIDTH-1:0] out_bank,
    output logic [ADDR_W-1:0]     out_addr,
    output type_t                 out_data
);

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [BANK_WIDTH-1:0] bank;
        logic [ADDR_W-1:0]     addr;
        logic                  hit;
        type_t                 data;
    } entry_t;

    entry_t iss_e;
    entry_t out_e;
    logic   unused_snoop;

    assign unused_snoop = ^{wea, banka, addra, dia};

    always_comb begin
        iss_e       = '0;
        iss_e.valid = iss_valid;
        iss_e.last  = iss_last;
        iss_e.bank  = iss_bank;
        iss_e.addr  = iss_addr;
    end

    if (OUTPUT_DELAY == 0) begin : g_bypass
        assign out_e = iss_e;
    end else begin : g_pipe
        entry_t stage_q [1:OUTPUT_DELAY];
        entry_t cur     [0:OUTPUT_DELAY-1];
        entry_t nxt     [0:OUTPUT_DELAY-1];

        always_comb begin
            cur[0] = iss_e;
            for (int unsigned k = 1; k < OUTPUT_DELAY; k++) begin
                cur[k] = stage_q[k];
            end
        end

        // Every entry not yet presented snoops the write port; newest write wins.
        always_comb begin
            for (int unsigned k = 0; k < OUTPUT_DELAY; k++) begin
                nxt[k] = cur[k];
`ifdef MEM_SCAN_WRITE_FWD_EN
                if (cur[k].valid && wea && cur[k].bank == banka && cur[k].addr == addra) begin
                    nxt[k].hit  = 1'b1;
                    nxt[k].data = dia;
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned k = 1; k <= OUTPUT_DELAY; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                for (int unsigned k = 0; k < OUTPUT_DELAY; k++) begin
                    stage_q[k+1] <= nxt[k];
                end
            end
        end

        assign out_e = stage_q[OUTPUT_DELAY];
    end

    assign out_valid = out_e.valid;
    assign out_last  = out_e.last;
    assign out_bank  = out_e.bank;
    assign out_addr  = out_e.addr;
    assign out_data  = out_e.valid ? (out_e.hit ? out_e.data : dob) : type_t'(0);

endmodule

// File: rtl/mem_bank_scan.sv
// Read-side scanner: walks every bank/address pair once per start pulse.
// MEM_SCAN_WRITE_FWD_EN enables forwarding of snooped writes to in-flight reads.
module mem_bank_scan
    import mem_scan_pkg::*;
#(
    parameter type          type_t       = logic,
    parameter int unsigned  DEPTH        = 0,
    parameter int unsigned  NUM_BANKS    = 0,
    parameter int unsigned  OUTPUT_DELAY = 0,
    parameter int unsigned  BANK_WIDTH   = idx_width(NUM_BANKS),
    localparam int unsigned ADDR_W       = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic                  reb,
    output logic [BANK_WIDTH-1:0] bankb,
    output logic [ADDR_W-1:0]     addrb,
    input  type_t                 dob,
    input  logic                  wea,
    input  logic [BANK_WIDTH-1:0] banka,
    input  logic [ADDR_W-1:0]     addra,
    input  type_t                 dia,
    output logic                  out_valid,
    output logic [BANK_WIDTH-1:0] out_bank,
    output logic [ADDR_W-1:0]     out_addr,
    output type_t                 out_data
);

    localparam int unsigned DRAIN_W = 2;

    state_t                state_q;
    logic                  busy_q;
    logic                  reb_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic                  addr_last;
    logic                  bank_last;
    logic                  pipe_last;

    assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));
    assign bank_last = (bank_q == BANK_WIDTH'(NUM_BANKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            reb_q   <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        reb_q   <= 1'b1;
                        bank_q  <= '0;
                        addr_q  <= '0;
                    end
                end
                ISSUE: begin
                    // Compare-and-wrap so non-power-of-two sizes never overflow.
                    if (addr_last) begin
                        addr_q <= '0;
                        if (bank_last) begin
                            bank_q  <= '0;
                            reb_q   <= 1'b0;
                            drain_q <= '0;
                            if (OUTPUT_DELAY == 0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            bank_q <= bank_q + 1'b1;
                        end
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_W'(OUTPUT_DELAY - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    reb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign reb     = reb_q;
    assign bankb   = bank_q;
    assign addrb   = addr_q;
    assign overrun = start && (state_q != IDLE);
    assign done    = out_valid && pipe_last;

    mem_scan_tag_pipe #(
        .type_t       (type_t),
        .OUTPUT_DELAY (OUTPUT_DELAY),
        .BANK_WIDTH   (BANK_WIDTH),
        .ADDR_W       (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (reb_q),
        .iss_last  (reb_q && addr_last && bank_last),
        .iss_bank  (bank_q),
        .iss_addr  (addr_q),
        .wea       (wea),
        .banka     (banka),
        .addra     (addra),
        .dia       (dia),
        .dob       (dob),
        .out_valid (out_valid),
        .out_last  (pipe_last),
        .out_bank  (out_bank),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

endmodule
